// File: rtl/control_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | control_pkg -- shared encodings for the LEGv8 control sequencer   |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package control_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_ADDS = 11'b10101011000;
    localparam logic [10:0] OP_SUBS = 11'b11101011000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [9:0]  OP_ADDI = 10'b1001000100;
    localparam logic [9:0]  OP_SUBI = 10'b1101000100;
    localparam logic [7:0]  OP_CBZ  = 8'b10110100;
    localparam logic [7:0]  OP_CBNZ = 8'b10110101;
    localparam logic [7:0]  OP_BCOND = 8'b01010100;
    localparam logic [5:0]  OP_B    = 6'b000101;

    localparam logic [4:0] FS_AND = 5'b00000;
    localparam logic [4:0] FS_ORR = 5'b00100;
    localparam logic [4:0] FS_ADD = 5'b01000;
    localparam logic [4:0] FS_SUB = 5'b01001;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;

    localparam logic [1:0] PC_HOLD   = 2'b00;
    localparam logic [1:0] PC_NEXT   = 2'b01;
    localparam logic [1:0] PC_BK     = 2'b10;
    localparam logic [1:0] PC_OFFSET = 2'b11;

    localparam int CW_DA_LSB  = 19;
    localparam int CW_SA_LSB  = 14;
    localparam int CW_SB_LSB  = 9;
    localparam int CW_FS_LSB  = 4;
    localparam int CW_REGW    = 3;
    localparam int CW_RAMW    = 2;
    localparam int CW_SELALU  = 1;
    localparam int CW_SELK    = 0;

    function automatic logic [23:0] pack_cw(
        input logic [4:0] da,
        input logic [4:0] sa,
        input logic [4:0] sb,
        input logic [4:0] fs,
        input logic       regw,
        input logic       ramw,
        input logic       selalu,
        input logic       selk
    );
        logic [23:0] cw;
        cw                   = '0;
        cw[CW_DA_LSB +: 5]   = da;
        cw[CW_SA_LSB +: 5]   = sa;
        cw[CW_SB_LSB +: 5]   = sb;
        cw[CW_FS_LSB +: 5]   = fs;
        cw[CW_REGW]          = regw;
        cw[CW_RAMW]          = ramw;
        cw[CW_SELALU]        = selalu;
        cw[CW_SELK]          = selk;
        return cw;
    endfunction

endpackage
`default_nettype wire

// File: rtl/branch_cond_eval.sv
`default_nettype none
// +------------------------------------------------------------------+
// | branch_cond_eval -- ARM condition code test on {V,C,N,Z}          |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module branch_cond_eval
    import control_pkg::*;
(
    input  logic [3:0] cond_i,
    input  logic [3:0] flags_i,
    output logic       taken_o
);

    logic v, c, n, z;
    assign {v, c, n, z} = flags_i;

    always_comb begin
        taken_o = 1'b1;
        case (cond_i)
            COND_EQ: taken_o = z;
            COND_NE: taken_o = !z;
            COND_CS: taken_o = c;
            COND_CC: taken_o = !c;
            COND_MI: taken_o = n;
            COND_PL: taken_o = !n;
            COND_VS: taken_o = v;
            COND_VC: taken_o = !v;
            COND_HI: taken_o = c && !z;
            COND_LS: taken_o = !(c && !z);
            COND_GE: taken_o = (n == v);
            COND_LT: taken_o = (n != v);
            COND_GT: taken_o = !z && (n == v);
            COND_LE: taken_o = z || (n != v);
            default: taken_o = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/control_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | control_sequencer -- two-cycle LEGv8 fetch/execute control unit   |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module control_sequencer
    import control_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] instruction,
    input  logic [3:0]  status,
    output logic [23:0] controlWord,
    output logic [63:0] K,
    output logic [1:0]  pcSel,
    output logic        halted
);

    state_t      state_q;
    logic [31:0] ir_q;
    logic [3:0]  flags_q;

    logic [10:0] op11;
    logic [9:0]  op10;
    logic [7:0]  op8;
    logic [5:0]  op6;
    logic [4:0]  rd, rn, rm;
    logic [63:0] k_imm, k_dt, k_cb, k_b;
    logic        is_rtype;
    logic [4:0]  rtype_fs;
    logic        bcond_taken;

    logic [23:0] dec_cw;
    logic [63:0] dec_k;
    logic [1:0]  dec_pc;
    logic        dec_legal;
    logic        dec_setflags;
    logic        exec_active;

    assign op11 = ir_q[31:21];
    assign op10 = ir_q[31:22];
    assign op8  = ir_q[31:24];
    assign op6  = ir_q[31:26];
    assign rd   = ir_q[4:0];
    assign rn   = ir_q[9:5];
    assign rm   = ir_q[20:16];

    assign k_imm = {52'd0, ir_q[21:10]};
    assign k_dt  = {{55{ir_q[20]}}, ir_q[20:12]};
    assign k_cb  = {{43{ir_q[23]}}, ir_q[23:5], 2'b00};
    assign k_b   = {{36{ir_q[25]}}, ir_q[25:0], 2'b00};

    assign is_rtype = op11 inside {OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_ADDS, OP_SUBS};
    assign rtype_fs = (op11 == OP_AND) ? FS_AND :
                      (op11 == OP_ORR) ? FS_ORR :
                      ((op11 == OP_SUB) || (op11 == OP_SUBS)) ? FS_SUB : FS_ADD;

    // B.cond tests the latched flags, never the live datapath status.
    branch_cond_eval u_cond (
        .cond_i  (ir_q[3:0]),
        .flags_i (flags_q),
        .taken_o (bcond_taken)
    );

    always_comb begin
        dec_cw       = '0;
        dec_k        = '0;
        dec_pc       = PC_HOLD;
        dec_legal    = 1'b1;
        dec_setflags = 1'b0;
        if (is_rtype) begin
            dec_cw       = pack_cw(rd, rn, rm, rtype_fs, 1'b1, 1'b0, 1'b1, 1'b0);
            dec_pc       = PC_NEXT;
            dec_setflags = (op11 == OP_ADDS) || (op11 == OP_SUBS);
        end else if ((op10 == OP_ADDI) || (op10 == OP_SUBI)) begin
            dec_cw = pack_cw(rd, rn, 5'd0, (op10 == OP_ADDI) ? FS_ADD : FS_SUB,
                             1'b1, 1'b0, 1'b1, 1'b1);
            dec_k  = k_imm;
            dec_pc = PC_NEXT;
        end else if (op11 == OP_LDUR) begin
            dec_cw = pack_cw(rd, rn, 5'd0, FS_ADD, 1'b1, 1'b0, 1'b0, 1'b1);
            dec_k  = k_dt;
            dec_pc = PC_NEXT;
        end else if (op11 == OP_STUR) begin
            dec_cw = pack_cw(5'd0, rn, rd, FS_ADD, 1'b0, 1'b1, 1'b0, 1'b1);
            dec_k  = k_dt;
            dec_pc = PC_NEXT;
        end else if (op6 == OP_B) begin
            dec_k  = k_b;
            dec_pc = PC_OFFSET;
        end else if ((op8 == OP_CBZ) || (op8 == OP_CBNZ)) begin
            // Zero test of Rt: XZR | Rt through the ALU, Z compared in the same cycle.
            dec_cw = pack_cw(5'd0, 5'd31, rd, FS_ORR, 1'b0, 1'b0, 1'b0, 1'b0);
            dec_k  = k_cb;
            dec_pc = (status[0] == (op8 == OP_CBZ)) ? PC_OFFSET : PC_NEXT;
        end else if (op8 == OP_BCOND) begin
            dec_k  = k_cb;
            dec_pc = bcond_taken ? PC_OFFSET : PC_NEXT;
        end else begin
            dec_legal = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_FETCH;
            ir_q    <= '0;
            flags_q <= '0;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    ir_q    <= instruction;
                    state_q <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (dec_setflags) begin
                        flags_q <= status;
                    end
                    state_q <= dec_legal ? ST_FETCH : ST_HALT;
                end
                ST_HALT:  state_q <= ST_HALT;
                default:  state_q <= ST_FETCH;
            endcase
        end
    end

    assign exec_active = (state_q == ST_EXEC) && !reset;
    assign controlWord = exec_active ? dec_cw : '0;
    assign K           = exec_active ? dec_k  : '0;
    assign pcSel       = exec_active ? dec_pc : PC_HOLD;
    assign halted      = (state_q == ST_HALT) && !reset;

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_control_sequencer -- randomized bench with behavioural model   |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_control_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] instruction;
    logic [3:0]  status;
    logic [23:0] controlWord;
    logic [63:0] K;
    logic [1:0]  pcSel;
    logic        halted;

    int checks = 0;
    int errors = 0;
    logic [3:0] m_flags = 4'h0;

    typedef struct {
        logic [23:0] cw;
        logic [63:0] k;
        logic [1:0]  pc;
        bit          setf;
        bit          kcare;
    } exp_t;

    control_sequencer dut (
        .clock       (clock),
        .reset       (reset),
        .instruction (instruction),
        .status      (status),
        .controlWord (controlWord),
        .K           (K),
        .pcSel       (pcSel),
        .halted      (halted)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic string mnemonic(input logic [31:0] ir);
        if (ir[31:21] == 11'b10001011000) return "ADD";
        if (ir[31:21] == 11'b11001011000) return "SUB";
        if (ir[31:21] == 11'b10001010000) return "AND";
        if (ir[31:21] == 11'b10101010000) return "ORR";
        if (ir[31:21] == 11'b10101011000) return "ADDS";
        if (ir[31:21] == 11'b11101011000) return "SUBS";
        if (ir[31:22] == 10'b1001000100)  return "ADDI";
        if (ir[31:22] == 10'b1101000100)  return "SUBI";
        if (ir[31:21] == 11'b11111000010) return "LDUR";
        if (ir[31:21] == 11'b11111000000) return "STUR";
        if (ir[31:26] == 6'b000101)       return "B";
        if (ir[31:24] == 8'b10110100)     return "CBZ";
        if (ir[31:24] == 8'b10110101)     return "CBNZ";
        if (ir[31:24] == 8'b01010100)     return "BCOND";
        return "UNDEF";
    endfunction

    // ARM rule: even code gives the base test, odd code its inverse; 14 and 15 always.
    function automatic bit cond_true(input int c, input logic [3:0] f);
        bit v, cy, n, z, r;
        v = f[3]; cy = f[2]; n = f[1]; z = f[0];
        case (c / 2)
            0:       r = z;
            1:       r = cy;
            2:       r = n;
            3:       r = v;
            4:       r = cy && !z;
            5:       r = (n == v);
            6:       r = !z && (n == v);
            default: r = 1'b1;
        endcase
        if ((c % 2 == 1) && (c < 14)) r = !r;
        return r;
    endfunction

    function automatic exp_t model(input logic [31:0] ir, input logic [3:0] st, input logic [3:0] fl);
        exp_t   e;
        string  m;
        int     da, sa, sb, fs, rw, mw, alu, sk, pc;
        longint off;
        m  = mnemonic(ir);
        da = 0; sa = 0; sb = 0; fs = 0; rw = 0; mw = 0; alu = 0; sk = 0; pc = 0; off = 0;
        e.setf  = (m == "ADDS") || (m == "SUBS");
        e.kcare = 1'b1;
        fs = (m == "AND") ? 0 : (m == "ORR") ? 4 :
             ((m == "SUB") || (m == "SUBS") || (m == "SUBI")) ? 9 : 8;
        if ((m == "ADD") || (m == "SUB") || (m == "AND") || (m == "ORR") || (m == "ADDS") || (m == "SUBS")) begin
            da = int'(ir[4:0]); sa = int'(ir[9:5]); sb = int'(ir[20:16]); rw = 1; alu = 1; pc = 1;
        end else if ((m == "ADDI") || (m == "SUBI")) begin
            da = int'(ir[4:0]); sa = int'(ir[9:5]); rw = 1; alu = 1; sk = 1; pc = 1;
            off = longint'(ir[21:10]);
        end else if (m == "LDUR") begin
            da = int'(ir[4:0]); sa = int'(ir[9:5]); fs = 8; rw = 1; sk = 1; pc = 1;
            off = longint'($signed(ir[20:12]));
        end else if (m == "STUR") begin
            sa = int'(ir[9:5]); sb = int'(ir[4:0]); fs = 8; mw = 1; sk = 1; pc = 1;
            off = longint'($signed(ir[20:12]));
        end else if (m == "B") begin
            fs = 0; pc = 3;
            off = longint'($signed(ir[25:0])) * 4;
        end else if ((m == "CBZ") || (m == "CBNZ")) begin
            sa = 31; sb = int'(ir[4:0]); fs = 4;
            off = longint'($signed(ir[23:5])) * 4;
            pc = ((st[0] == 1'b1) == (m == "CBZ")) ? 3 : 1;
        end else if (m == "BCOND") begin
            fs = 0;
            off = longint'($signed(ir[23:5])) * 4;
            pc = cond_true(int'(ir[3:0]), fl) ? 3 : 1;
            e.kcare = (pc == 3);
        end else begin
            fs = 0;
        end
        e.cw = 24'((da << 19) | (sa << 14) | (sb << 9) | (fs << 4) | (rw << 3) | (mw << 2) | (alu << 1) | sk);
        e.k  = 64'(off);
        e.pc = 2'(pc);
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 13))
            0:       return {11'b10001011000, r[20:0]};
            1:       return {11'b11001011000, r[20:0]};
            2:       return {11'b10001010000, r[20:0]};
            3:       return {11'b10101010000, r[20:0]};
            4:       return {11'b10101011000, r[20:0]};
            5:       return {11'b11101011000, r[20:0]};
            6:       return {10'b1001000100, r[21:0]};
            7:       return {10'b1101000100, r[21:0]};
            8:       return {11'b11111000010, r[20:0]};
            9:       return {11'b11111000000, r[20:0]};
            10:      return {6'b000101, r[25:0]};
            11:      return {7'b1011010, r[24:0]};
            default: return {8'b01010100, r[23:0]};
        endcase
    endfunction

    // Entered one step after a rising edge with the DUT in FETCH; leaves likewise.
    task automatic run_instr(input logic [31:0] ins, input logic [3:0] st, input string tag,
                             output logic [23:0] o_cw, output logic [63:0] o_k, output logic [1:0] o_pc);
        exp_t e;
        instruction = ins;
        status      = 4'($urandom);
        #4;
        check({tag, ".fetch_cw"}, 64'(controlWord), 64'h0);
        check({tag, ".fetch_pc"}, 64'(pcSel), 64'h0);
        check({tag, ".fetch_k"}, K, 64'h0);
        check({tag, ".fetch_halt"}, 64'(halted), 64'h0);
        @(posedge clock); #1;
        instruction = $urandom;
        status      = st;
        e = model(ins, st, m_flags);
        #4;
        o_cw = controlWord; o_k = K; o_pc = pcSel;
        check({tag, ".cw"}, 64'(controlWord), 64'(e.cw));
        check({tag, ".pc"}, 64'(pcSel), 64'(e.pc));
        if (e.kcare) check({tag, ".k"}, K, e.k);
        check({tag, ".halt"}, 64'(halted), 64'h0);
        @(posedge clock); #1;
        if (e.setf) m_flags = st;
    endtask

    logic [23:0] ocw;
    logic [63:0] ok;
    logic [1:0]  opc;
    logic [31:0] add_x3;

    initial begin
        add_x3      = 32'h8B020023;
        reset       = 1'b1;
        instruction = 32'h0;
        status      = 4'h0;
        @(posedge clock); #1;
        instruction = $urandom;
        #4;
        check("rst.cw", 64'(controlWord), 64'h0);
        check("rst.pc", 64'(pcSel), 64'h0);
        check("rst.k", K, 64'h0);
        check("rst.halt", 64'(halted), 64'h0);
        @(posedge clock); #1;
        reset   = 1'b0;
        m_flags = 4'h0;

        run_instr(add_x3, 4'h0, "add", ocw, ok, opc);
        check("add.cw_const", 64'(ocw), 64'h18448A);
        check("add.pc_const", 64'(opc), 64'h1);

        run_instr({11'b11111000010, 9'h1F8, 2'b00, 5'd1, 5'd5}, 4'h0, "ldur", ocw, ok, opc);
        check("ldur.k_const", ok, 64'hFFFF_FFFF_FFFF_FFF8);
        check("ldur.da", 64'(ocw[23:19]), 64'd5);
        check("ldur.sa", 64'(ocw[18:14]), 64'd1);
        check("ldur.selk_alu_regw", 64'({ocw[3], ocw[1], ocw[0]}), 64'b101);

        run_instr({8'b10110100, 19'd3, 5'd4}, 4'b0001, "cbz_t", ocw, ok, opc);
        check("cbz_t.pc_const", 64'(opc), 64'h3);
        check("cbz_t.k_const", ok, 64'd12);
        check("cbz_t.writes", 64'(ocw[3:2]), 64'h0);
        run_instr({8'b10110100, 19'd3, 5'd4}, 4'b0000, "cbz_n", ocw, ok, opc);
        check("cbz_n.pc_const", 64'(opc), 64'h1);
        check("cbz_n.writes", 64'(ocw[3:2]), 64'h0);

        run_instr({11'b11101011000, 5'd2, 6'd0, 5'd1, 5'd3}, 4'b0001, "subs1", ocw, ok, opc);
        run_instr({8'b01010100, 19'd5, 1'b0, 4'h1}, 4'h0, "bne", ocw, ok, opc);
        check("bne.pc_const", 64'(opc), 64'h1);
        run_instr({11'b11101011000, 5'd2, 6'd0, 5'd1, 5'd3}, 4'b0001, "subs2", ocw, ok, opc);
        run_instr({8'b01010100, 19'd5, 1'b0, 4'h0}, 4'h0, "beq", ocw, ok, opc);
        check("beq.pc_const", 64'(opc), 64'h3);

        for (int i = 0; i < 400; i++) begin
            run_instr(rand_instr(), 4'($urandom), "rnd", ocw, ok, opc);
        end

        // Reset landing on the EXEC cycle of a store must suppress the write.
        instruction = {11'b11111000000, 9'h010, 2'b00, 5'd2, 5'd7};
        #4;
        @(posedge clock); #1;
        reset       = 1'b1;
        instruction = $urandom;
        #4;
        check("stur_rst.ramw", 64'(controlWord[2]), 64'h0);
        check("stur_rst.pc", 64'(pcSel), 64'h0);
        check("stur_rst.cw", 64'(controlWord), 64'h0);
        @(posedge clock); #1;
        reset   = 1'b0;
        m_flags = 4'h0;
        run_instr(add_x3, 4'h0, "post_rst", ocw, ok, opc);

        // Undefined opcode drives HALT until reset.
        instruction = 32'h0;
        #4;
        @(posedge clock); #1;
        instruction = $urandom;
        #4;
        check("undef.exec_cw", 64'(controlWord), 64'h0);
        check("undef.exec_pc", 64'(pcSel), 64'h0);
        check("undef.exec_halt", 64'(halted), 64'h0);
        @(posedge clock); #1;
        for (int i = 0; i < 12; i++) begin
            instruction = $urandom;
            status      = 4'($urandom);
            #4;
            check("halt.halted", 64'(halted), 64'h1);
            check("halt.cw", 64'(controlWord), 64'h0);
            check("halt.pc", 64'(pcSel), 64'h0);
            @(posedge clock); #1;
        end
        reset = 1'b1;
        #4;
        @(posedge clock); #1;
        reset   = 1'b0;
        m_flags = 4'h0;
        run_instr(add_x3, 4'h0, "after_halt", ocw, ok, opc);
        check("after_halt.cw_const", 64'(ocw), 64'h18448A);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/control_sequencer.md
# control_sequencer

Multi-cycle control unit that drives the register/ALU/RAM datapath. It fetches a 32-bit LEGv8 instruction from the instruction ROM and latches it. It then decodes the instruction and emits the 24-bit datapath control word, the 64-bit constant `K`, and the PC-select code. It also consumes the datapath status flags for conditional branches and keeps its own latched flag register for `ADDS`/`SUBS` followed by `B.cond`.

## Interface
Parameters:
- none. All widths are fixed by the datapath.

Ports:
- `clock`  in  1  single system clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `instruction`  in  32  ROM output at the current PC; combinational and stable while PC is held.
- `status`  in  4  datapath flags `{V,C,N,Z}`, combinational from the current control word.
- `controlWord`  out  24  `{DA[23:19], SA[18:14], SB[13:9], FS[8:4], regW[3], ramW[2], selALU[1], selK[0]}`.
- `K`  out  64  constant routed to the ALU B input when `selK`=1; branch byte offset when branching.
- `pcSel`  out  2  PC mux select: 00 hold, 01 PC+4, 10 B/K, 11 PC+offset.
- `halted`  out  1  high in HALT state.

## Operation
- States are FETCH, EXEC and HALT. Reset enters FETCH.
- **FETCH**
  - IR <= `instruction`.
  - Outputs idle: `controlWord`=0, `K`=0, `pcSel`=00.
  - Next state is EXEC.
- **EXEC**
  - Decode IR and drive outputs combinationally.
  - `ADDS`/`SUBS` latch `status` into FLAGS at the end of EXEC.
  - Next state is FETCH, or HALT on an undefined opcode.
- **HALT**
  - Outputs idle; `halted`=1.
  - Leaves only on `reset`.
- FS codes: AND=00000, ORR=00100, ADD=01000, SUB=01001.
- R-type (`ADD` 10001011000, `SUB` 11001011000, `AND` 10001010000, `ORR` 10101010000, `ADDS` 10101011000, `SUBS` 11101011000):
  - DA=Rd[4:0], SA=Rn[9:5], SB=Rm[20:16].
  - regW=1, selALU=1, selK=0, pcSel=01.
- `ADDI` (1001000100) / `SUBI` (1101000100):
  - K = zero-extended imm12[21:10]; selK=1, SB=0.
  - Otherwise as R-type.
- `LDUR` (11111000010):
  - DA=Rt, SA=Rn, FS=ADD, selK=1, K = sign-extended addr9[20:12].
  - selALU=0, regW=1.
- `STUR` (11111000000):
  - SA=Rn, SB=Rt, FS=ADD, selK=1, K as LDUR.
  - ramW=1, regW=0.
- `B` (000101): K = sign-extended imm26 << 2, pcSel=11, no writes.
- `CBZ` (10110100) / `CBNZ` (10110101):
  - SA=31 (XZR), SB=Rt, FS=ORR, selK=0.
  - K = sign-extended imm19[23:5] << 2.
  - pcSel=11 if `status`.Z matches the condition (Z=1 for CBZ, Z=0 for CBNZ), else 01.
- `B.cond` (01010100):
  - Condition IR[3:0] is evaluated on FLAGS, not on `status`.
  - Codes 0000–1101 follow the standard ARM EQ..LE set; 1110/1111 always taken.
  - Taken gives pcSel=11 with K = imm19<<2; not taken gives pcSel=01.
- Any other opcode: idle outputs during EXEC, then HALT.

## Timing
- Each instruction takes 2 cycles. PC changes only at the clock edge that ends EXEC.
- `pcSel` for CBZ/CBNZ depends combinationally on `status` in the same cycle. No register sits in that path.
- Reset values: state=FETCH, IR=0, FLAGS=0, `controlWord`=0, `K`=0, `pcSel`=00, `halted`=0.
- While `reset`=1, outputs are forced idle in every state. No write or PC update commits during a reset cycle, including mid-EXEC.
- FLAGS update only in EXEC of ADDS/SUBS. A `B.cond` immediately after them sees the new value.
- Sign extension is always to 64 bits. Shifted offsets wrap modulo 2^64.

## Structure
- Package `control_pkg` holds:
  - state enum;
  - opcode constants;
  - FS constants;
  - condition codes;
  - control-word bit positions.
- Sub-module `branch_cond_eval` (combinational) maps a 4-bit condition and `{V,C,N,Z}` to taken.
- The top level holds the FSM, IR, FLAGS and the decode logic.

## Test plan
- `ADD X3,X1,X2` (0x8B020023), 2 cycles:
  - FETCH gives `controlWord`=0, `pcSel`=00.
  - EXEC gives `controlWord`=0x18448A, `pcSel`=01.
- `LDUR X5,[X1,#-8]` in EXEC:
  - DA=5, SA=1, selK=1, selALU=0, regW=1.
  - `K`=0xFFFFFFFFFFFFFFF8.
- `CBZ X4,#+3`:
  - With `status`=0001, `pcSel`=11 and `K`=12.
  - With `status`=0000, `pcSel`=01. No writes in either case.
- `SUBS` with `status`=0001, then `B.NE`, gives `pcSel`=01. Replacing it with `B.EQ` gives `pcSel`=11.
- Instruction 0x00000000:
  - `halted`=1 from the cycle after EXEC, with outputs idle for 10+ cycles.
  - `reset` returns the block to FETCH, with `halted`=0 the next cycle.
- `reset` asserted during EXEC of `STUR`: `ramW`=0 and `pcSel`=00 in that cycle, and state is FETCH afterward.
